// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared widths and controller state type for the layer sequencer
package nn_seq_pkg;
  localparam int PK_WIDTH = 7;
  localparam int PK_LEN = 9;
  localparam int VEC_W = 63;
  typedef enum logic [3:0] {
    IDLE, FWD_ISSUE, FWD_WAIT, FWD_ACK, BWD_ISSUE, BWD_WAIT, BWD_ACK, DONE, ERROR
  } state_e;
endpackage

// File: rtl/nn_seq_watchdog.sv
// nn_seq_watchdog: wait-state timeout counter, present only when NN_SEQ_WATCHDOG_EN is defined
module nn_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
`ifdef NN_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk)
    if (reset || clear) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused;
  assign unused = ^{clk, reset, clear, enable};
  assign expired = 1'b0;
`endif
endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: forward/backprop step controller for chained layers; watchdog via NN_SEQ_WATCHDOG_EN
module nn_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [VEC_W-1:0]            sample_vec,
  input  logic [VEC_W-1:0]            target_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [VEC_W-1:0]            result_vec,
  output logic [NUM_LAYERS-1:0]       layer_mult,
  output logic [NUM_LAYERS-1:0]       layer_backprop,
  output logic [NUM_LAYERS-1:0]       layer_ack,
  output logic [NUM_LAYERS-1:0]       layer_output_layer,
  input  logic [NUM_LAYERS-1:0]       layer_valid,
  output logic [VEC_W-1:0]            layer_in_vec,
  input  logic [VEC_W*NUM_LAYERS-1:0] layer_out_vec
);
  localparam int IW = $clog2(NUM_LAYERS);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d, tgt_q, tgt_d, res_q, res_d;
  logic [NUM_LAYERS-1:0] sel;
  logic expired, last;
  assign sel = NUM_LAYERS'(1) << idx_q;
  assign last = idx_q == IW'(NUM_LAYERS - 1);
  nn_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(state_q == FWD_ISSUE || state_q == BWD_ISSUE),
    .enable(state_q == FWD_WAIT || state_q == BWD_WAIT),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vec_d = vec_q;
    tgt_d = tgt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FWD_ISSUE;
        vec_d = sample_vec;
        tgt_d = target_vec;
        idx_d = '0;
      end
      FWD_ISSUE: state_d = FWD_WAIT;
      BWD_ISSUE: state_d = BWD_WAIT;
      FWD_WAIT, BWD_WAIT: if (layer_valid[idx_q]) begin
        vec_d = layer_out_vec[idx_q*VEC_W +: VEC_W];
        state_d = (state_q == FWD_WAIT) ? FWD_ACK : BWD_ACK;
      end else if (expired) state_d = ERROR;
      FWD_ACK: if (!last) begin
        idx_d = idx_q + 1'b1;
        state_d = FWD_ISSUE;
      end else begin
        // the backward pass starts from the same last layer with the target as its input
        res_d = vec_q;
        vec_d = tgt_q;
        state_d = BWD_ISSUE;
      end
      BWD_ACK: if (idx_q != '0) begin
        idx_d = idx_q - 1'b1;
        state_d = BWD_ISSUE;
      end else state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      vec_q <= '0;
      tgt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vec_q <= vec_d;
      tgt_q <= tgt_d;
      res_q <= res_d;
    end
  assign layer_mult = (state_q == FWD_ISSUE) ? sel : '0;
  assign layer_backprop = (state_q == BWD_ISSUE) ? sel : '0;
  assign layer_ack = (state_q == FWD_ACK || state_q == BWD_ACK) ? sel : '0;
  assign layer_output_layer = NUM_LAYERS'(1) << (NUM_LAYERS - 1);
  assign layer_in_vec = vec_q;
  assign result_vec = res_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
`ifdef NN_SEQ_WATCHDOG_EN
  assign error = state_q == ERROR;
`else
  assign error = 1'b0;
`endif
endmodule
